// File: rtl/mips_btb.sv
// ---------------------------------------------------------------------------
// mips_btb -- direct-mapped branch target buffer with 2-bit direction counters
//
// Purpose:
//   Predicts the next fetch PC for the instruction at LookupPc. Each entry
//   holds a valid bit, a tag, a branch target and a 2-bit saturating counter.
//   Lookup is purely combinational from the registered array. Resolved
//   branches train the array on the following rising edge.
//
// Ports:
//   ClockPulse    in   1       rising-edge clock for all state
//   Reset         in   1       asynchronous active-high reset
//   LookupPc      in   ADDR_W  PC being fetched
//   Hit           out  1       valid entry with matching tag for LookupPc
//   PredictTaken  out  1       predicted direction (Hit AND counter MSB)
//   PredictedPc   out  ADDR_W  target if predicted taken, else LookupPc+4
//   UpdateEn      in   1       a resolved branch is presented this cycle
//   UpdatePc      in   ADDR_W  PC of the resolved branch
//   UpdateTaken   in   1       resolved direction
//   UpdateTarget  in   ADDR_W  resolved target address
//   Flush         in   1       invalidate every entry (wins over UpdateEn)
// ---------------------------------------------------------------------------
module mips_btb #(
   parameter int ADDR_W  = 32,
   parameter int ENTRIES = 16
) (
   input  logic              ClockPulse,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] LookupPc,
   output logic              Hit,
   output logic              PredictTaken,
   output logic [ADDR_W-1:0] PredictedPc,
   input  logic              UpdateEn,
   input  logic [ADDR_W-1:0] UpdatePc,
   input  logic              UpdateTaken,
   input  logic [ADDR_W-1:0] UpdateTarget,
   input  logic              Flush
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   // Counter encodings: MSB set means "predict taken".
   localparam logic [1:0] CTR_STRONG_NT = 2'b00;
   localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
   localparam logic [1:0] CTR_WEAK_T    = 2'b10;
   localparam logic [1:0] CTR_STRONG_T  = 2'b11;

   // ------------------------------------------------------------------------
   // Entry storage
   // ------------------------------------------------------------------------
   logic              valid_q  [ENTRIES];
   logic              valid_d  [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [TAG_W-1:0]  tag_d    [ENTRIES];
   logic [ADDR_W-1:0] target_q [ENTRIES];
   logic [ADDR_W-1:0] target_d [ENTRIES];
   logic [1:0]        ctr_q    [ENTRIES];
   logic [1:0]        ctr_d    [ENTRIES];

   // ------------------------------------------------------------------------
   // Saturating counter helpers
   // ------------------------------------------------------------------------
   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      return (c == CTR_STRONG_T) ? c : c + 2'b01;
   endfunction

   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      return (c == CTR_STRONG_NT) ? c : c - 2'b01;
   endfunction

   // ------------------------------------------------------------------------
   // Address decomposition. PC[1:0] never participates: instructions are
   // word aligned, so those bits carry no information for the predictor.
   // ------------------------------------------------------------------------
   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             unused_pc_bits;

   assign lk_idx = LookupPc[IDX_W+1:2];
   assign lk_tag = LookupPc[ADDR_W-1:IDX_W+2];
   assign up_idx = UpdatePc[IDX_W+1:2];
   assign up_tag = UpdatePc[ADDR_W-1:IDX_W+2];

   assign unused_pc_bits = ^{LookupPc[1:0], UpdatePc[1:0]};

   // ------------------------------------------------------------------------
   // Lookup path: reads the registered array only, so a same-cycle update
   // to the looked-up index is not visible until the following cycle.
   // ------------------------------------------------------------------------
   logic lk_hit;
   logic lk_taken;

   always_comb begin
      // NOTE: combinational blocks use blocking '=' and give every output a
      // default first so no path leaves a signal unassigned (no latches).
      lk_hit      = 1'b0;
      lk_taken    = 1'b0;
      PredictedPc = LookupPc + ADDR_W'(4);

      // Reset is folded in explicitly so the outputs are forced the instant
      // Reset rises, independent of how the array reset is implemented.
      if (!Reset) begin
         lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
         lk_taken = lk_hit && ctr_q[lk_idx][1];
         if (lk_taken) begin
            PredictedPc = target_q[lk_idx];
         end
      end
   end

   assign Hit          = lk_hit;
   assign PredictTaken = lk_taken;

   // ------------------------------------------------------------------------
   // Update path: compute next contents of the whole array.
   // ------------------------------------------------------------------------
   logic up_hit;

   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         valid_d[i]  = valid_q[i];
         tag_d[i]    = tag_q[i];
         target_d[i] = target_q[i];
         ctr_d[i]    = ctr_q[i];
      end

      if (Flush) begin
         // Only valid bits are cleared; stale tags/targets/counters become
         // unreachable and are overwritten by the next allocation.
         for (int i = 0; i < ENTRIES; i++) begin
            valid_d[i] = 1'b0;
         end
      end else if (UpdateEn) begin
         if (up_hit) begin
            if (UpdateTaken) begin
               ctr_d[up_idx]    = ctr_inc(ctr_q[up_idx]);
               target_d[up_idx] = UpdateTarget;
            end else begin
               ctr_d[up_idx]    = ctr_dec(ctr_q[up_idx]);
            end
         end else if (UpdateTaken) begin
            // Allocate (replacing any alias) starting weakly taken, so one
            // not-taken outcome is enough to flip the prediction.
            valid_d[up_idx]  = 1'b1;
            tag_d[up_idx]    = up_tag;
            target_d[up_idx] = UpdateTarget;
            ctr_d[up_idx]    = CTR_WEAK_T;
         end
         // A not-taken miss is not worth an entry: the fall-through PC is
         // already the default prediction.
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge ClockPulse or posedge Reset) begin
      if (Reset) begin
         // NOTE: the array is deliberately reset (not left to power-up
         // values) so counters start weakly not-taken and tags/targets are
         // deterministic; this costs a reset fan-out to every entry bit.
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WEAK_NT;
         end
      end else begin
         // NOTE: sequential state uses non-blocking '<=' so every flop
         // samples the pre-edge values regardless of statement order.
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= valid_d[i];
            tag_q[i]    <= tag_d[i];
            target_q[i] <= target_d[i];
            ctr_q[i]    <= ctr_d[i];
         end
      end
   end

endmodule

// File: tb/tb_mips_btb.sv
// ---------------------------------------------------------------------------
// tb_mips_btb -- self-checking bench for mips_btb (ADDR_W=32, ENTRIES=16).
// A behavioural table model (integer index/tag arithmetic, clamped integer
// counters) predicts the outputs; a compare process checks them on every
// falling edge. Directed lookups with literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_mips_btb;

   localparam int ADDR_W  = 32;
   localparam int ENTRIES = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [ADDR_W-1:0] lookup_pc = '0;
   logic              hit;
   logic              predict_taken;
   logic [ADDR_W-1:0] predicted_pc;
   logic              update_en = 1'b0;
   logic [ADDR_W-1:0] update_pc = '0;
   logic              update_taken = 1'b0;
   logic [ADDR_W-1:0] update_target = '0;
   logic              flush = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   always #5 clk = ~clk;

   mips_btb #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES)) dut (
      .ClockPulse  (clk),
      .Reset       (rst),
      .LookupPc    (lookup_pc),
      .Hit         (hit),
      .PredictTaken(predict_taken),
      .PredictedPc (predicted_pc),
      .UpdateEn    (update_en),
      .UpdatePc    (update_pc),
      .UpdateTaken (update_taken),
      .UpdateTarget(update_target),
      .Flush       (flush)
   );

   // ------------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------------
   bit          m_valid  [ENTRIES];
   int unsigned m_tag    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   int          m_ctr    [ENTRIES];

   function automatic int unsigned idx_of(input logic [31:0] pc);
      return (pc / 4) % ENTRIES;
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return pc / (4 * ENTRIES);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  <= 1'b0;
            m_tag[i]    <= 0;
            m_target[i] <= '0;
            m_ctr[i]    <= 1;
         end
      end else if (flush) begin
         for (int i = 0; i < ENTRIES; i++) m_valid[i] <= 1'b0;
      end else if (update_en) begin
         int unsigned ui;
         ui = idx_of(update_pc);
         if (m_valid[ui] && m_tag[ui] == tag_of(update_pc)) begin
            if (update_taken) begin
               m_ctr[ui]    <= (m_ctr[ui] + 1 > 3) ? 3 : m_ctr[ui] + 1;
               m_target[ui] <= update_target;
            end else begin
               m_ctr[ui]    <= (m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1;
            end
         end else if (update_taken) begin
            m_valid[ui]  <= 1'b1;
            m_tag[ui]    <= tag_of(update_pc);
            m_target[ui] <= update_target;
            m_ctr[ui]    <= 2;
         end
      end
   end

   function automatic void predict(input logic [31:0] pc, output logic e_hit,
                                   output logic e_taken, output logic [31:0] e_pc);
      int unsigned i;
      i       = idx_of(pc);
      e_hit   = m_valid[i] && (m_tag[i] == tag_of(pc));
      e_taken = e_hit && (m_ctr[i] >= 2);
      e_pc    = e_taken ? m_target[i] : pc + 32'd4;
   endfunction

   // ------------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         logic        e_hit, e_taken;
         logic [31:0] e_pc;
         predict(lookup_pc, e_hit, e_taken, e_pc);
         check("cmp_hit",   {31'd0, hit},           {31'd0, e_hit});
         check("cmp_taken", {31'd0, predict_taken}, {31'd0, e_taken});
         check("cmp_pc",    predicted_pc,           e_pc);
      end
   end

   // Literal expectation for a lookup, evaluated 1 time unit after driving.
   task automatic look(input logic [31:0] pc, input logic e_hit, input logic e_taken,
                       input logic [31:0] e_pc, input string name);
      lookup_pc = pc;
      #1;
      check({name, "_hit"},   {31'd0, hit},           {31'd0, e_hit});
      check({name, "_taken"}, {31'd0, predict_taken}, {31'd0, e_taken});
      check({name, "_pc"},    predicted_pc,           e_pc);
   endtask

   task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
      update_en     = 1'b1;
      update_pc     = pc;
      update_taken  = taken;
      update_target = tgt;
   endtask

   // Advance past the next rising edge and return inputs to idle.
   task automatic tick();
      @(posedge clk);
      #1;
      update_en = 1'b0;
      flush     = 1'b0;
   endtask

   function automatic logic [31:0] gen_pc();
      logic [31:0] tag;
      tag = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 3));
      return (tag << 6) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      #2 rst = 1'b1;
      cmp_en = 1'b1;
      look(32'h1234, 1'b0, 1'b0, 32'h1238, "reset_out");
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      tick();

      look(32'h40, 1'b0, 1'b0, 32'h44, "cold_miss");

      // Allocation, same-cycle lookup sees old contents.
      upd(32'h40, 1'b1, 32'h100);
      look(32'h40, 1'b0, 1'b0, 32'h44, "alloc_same_cycle");
      tick();
      look(32'h40, 1'b1, 1'b1, 32'h100, "alloc_next");

      // Hysteresis and saturation.
      upd(32'h40, 1'b0, 32'h0); tick();
      look(32'h40, 1'b1, 1'b0, 32'h44, "hyst_nt1");
      upd(32'h40, 1'b0, 32'h0); tick();
      upd(32'h40, 1'b0, 32'h0); tick();
      look(32'h40, 1'b1, 1'b0, 32'h44, "hyst_nt3");
      upd(32'h40, 1'b1, 32'h100); tick();
      look(32'h40, 1'b1, 1'b0, 32'h44, "hyst_t1");
      upd(32'h40, 1'b1, 32'h100); tick();
      look(32'h40, 1'b1, 1'b1, 32'h100, "hyst_t2");
      repeat (3) begin upd(32'h40, 1'b1, 32'h100); tick(); end
      upd(32'h40, 1'b0, 32'h0); tick();
      look(32'h40, 1'b1, 1'b1, 32'h100, "sat_nt1");
      upd(32'h40, 1'b0, 32'h0); tick();
      look(32'h40, 1'b1, 1'b0, 32'h44, "sat_nt2");
      upd(32'h43, 1'b1, 32'h104); tick();
      look(32'h40, 1'b1, 1'b1, 32'h104, "target_overwrite");

      // Aliasing on index 0.
      look(32'h80, 1'b0, 1'b0, 32'h84, "alias_miss");
      upd(32'h80, 1'b1, 32'h200); tick();
      look(32'h80, 1'b1, 1'b1, 32'h200, "alias_alloc");
      look(32'h40, 1'b0, 1'b0, 32'h44, "alias_evict");
      upd(32'hC0, 1'b0, 32'h300); tick();
      look(32'h80, 1'b1, 1'b1, 32'h200, "nt_miss_keep");
      look(32'hC0, 1'b0, 1'b0, 32'hC4, "nt_miss_none");

      // Another index, then confirm index 0 untouched.
      upd(32'h14, 1'b1, 32'h500); tick();
      look(32'h14, 1'b1, 1'b1, 32'h500, "idx5_alloc");
      look(32'h80, 1'b1, 1'b1, 32'h200, "idx0_intact");

      // Flush beats a simultaneous update.
      upd(32'h10, 1'b1, 32'h600);
      flush = 1'b1;
      tick();
      look(32'h10, 1'b0, 1'b0, 32'h14, "flush_10");
      look(32'h40, 1'b0, 1'b0, 32'h44, "flush_40");
      look(32'h80, 1'b0, 1'b0, 32'h84, "flush_80");
      look(32'h14, 1'b0, 1'b0, 32'h18, "flush_14");

      // Asynchronous reset mid-cycle; update held through reset is ignored.
      upd(32'h40, 1'b1, 32'h100); tick();
      look(32'h40, 1'b1, 1'b1, 32'h100, "pre_reset");
      upd(32'h40, 1'b1, 32'h700);
      #1 rst = 1'b1;
      look(32'h40, 1'b0, 1'b0, 32'h44, "async_reset");
      @(posedge clk);
      #1 rst = 1'b0;
      update_en = 1'b0;
      look(32'h40, 1'b0, 1'b0, 32'h44, "post_reset");
      tick();
      look(32'h40, 1'b0, 1'b0, 32'h44, "post_reset_edge");

      // Randomized traffic checked by the compare process.
      for (int n = 0; n < 3000; n++) begin
         update_en     = ($urandom_range(0, 1) == 1);
         update_pc     = gen_pc();
         update_taken  = ($urandom_range(0, 3) != 0);
         update_target = 32'($urandom) & ~32'h3;
         flush         = ($urandom_range(0, 40) == 0);
         lookup_pc     = ($urandom_range(0, 2) == 0) ? update_pc : gen_pc();
         if (rst) begin
            rst = 1'b0;
         end else if ($urandom_range(0, 250) == 0) begin
            #1 rst = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      update_en = 1'b0;
      flush     = 1'b0;
      rst       = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
